// File: rtl/nn_pkg.sv
// nn_pkg: shared definitions for the fixed-point dense-layer pipeline.
//   DATA_W   - width of activations, weights, biases and results
//   FRAC_DEF - default number of fractional bits of the shared Q format
//   state_e  - layer sequencer states
//   sat8     - clamp a signed value to the signed 8-bit range
//   w_off    - bit offset of weight row j, column i in a packed weight ROM
package nn_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned FRAC_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN,
        DONE
    } state_e;

    function automatic logic signed [DATA_W-1:0] sat8(input logic signed [31:0] v);
        if (v > 32'sd127) begin
            return 8'h7f;
        end else if (v < -32'sd128) begin
            return 8'h80;
        end
        return v[DATA_W-1:0];
    endfunction

    function automatic int unsigned w_off(input int unsigned j, input int unsigned i,
                                          input int unsigned n_in);
        return (j * n_in + i) * DATA_W;
    endfunction

endpackage

// File: rtl/nn_dense_layer_if.sv
// nn_dense_layer_if: handshake, activation read port and result bus of one layer.
//   req        - start/hold request from upstream
//   in_data    - activation read data, valid the cycle after its address is presented
//   in_rd_trig - read strobe, high whenever in_addr carries a valid read address
//   in_addr    - activation index being read
//   ack_layer  - results valid (level)
//   out_vec    - packed signed results, neuron j at [j*8 +: 8]
// Modports: master = upstream/memory side, slave = layer side.
interface nn_dense_layer_if
    import nn_pkg::*;
#(
    parameter int unsigned N_IN  = 2,
    parameter int unsigned N_OUT = 2
);
    localparam int unsigned AW = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic                       req;
    logic signed [DATA_W-1:0]   in_data;
    logic                       in_rd_trig;
    logic [AW-1:0]              in_addr;
    logic                       ack_layer;
    logic [N_OUT*DATA_W-1:0]    out_vec;

    modport master (
        output req,
        output in_data,
        input  in_rd_trig,
        input  in_addr,
        input  ack_layer,
        input  out_vec
    );

    modport slave (
        input  req,
        input  in_data,
        output in_rd_trig,
        output in_addr,
        output ack_layer,
        output out_vec
    );

endinterface

// File: rtl/nn_mac_unit.sv
// nn_mac_unit: signed 8x8 multiply-accumulate with a combinational post-stage.
//   clk, rst  - clock and asynchronous active-high reset
//   clr_i     - zero the accumulator (wins over en_i)
//   en_i      - accumulate data_i * weight_i
//   data_i    - signed activation
//   weight_i  - signed weight for the current MAC
//   bias_i    - signed bias of the current neuron
//   res_o     - (acc + bias<<FRAC) >>> FRAC, optional ReLU, saturated to 8 bits
module nn_mac_unit
    import nn_pkg::*;
#(
    parameter int unsigned FRAC  = FRAC_DEF,
    parameter int unsigned ACC_W = 18,
    parameter int unsigned ACT   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] data_i,
    input  logic signed [DATA_W-1:0] weight_i,
    input  logic signed [DATA_W-1:0] bias_i,
    output logic signed [DATA_W-1:0] res_o
);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [15:0]      prod;
    logic signed [ACC_W:0]   bias_ext;
    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W:0]   shifted;
    logic signed [31:0]      v;

    always_comb begin
        prod  = $signed({{8{data_i[7]}}, data_i}) * $signed({{8{weight_i[7]}}, weight_i});
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + {{(ACC_W-16){prod[15]}}, prod};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // One extra bit of headroom so the bias add cannot wrap a near-full accumulator.
    always_comb begin
        bias_ext = {{(ACC_W+1-DATA_W){bias_i[DATA_W-1]}}, bias_i};
        sum      = {acc_q[ACC_W-1], acc_q} + (bias_ext <<< FRAC);
        shifted  = sum >>> FRAC;  // arithmetic: rounds toward minus infinity
        v        = {{(31-ACC_W){shifted[ACC_W]}}, shifted};
        if (ACT == 1 && shifted[ACC_W]) begin
            v = '0;
        end
        res_o = sat8(v);
    end

endmodule

// File: rtl/nn_dense_layer.sv
// nn_dense_layer: fixed-point fully-connected layer, one neuron at a time.
//   clk, rst - clock and asynchronous active-high reset
//   bus_io   - slave side of nn_dense_layer_if (req, activation read port, results)
// Each neuron takes N_IN+2 cycles: N_IN reads pipelined with N_IN MACs, then one
// FIN cycle that post-processes the accumulator into its shadow slot. Results are
// copied to out_vec only when the last neuron completes, so an abort never
// disturbs previously published results.
module nn_dense_layer
    import nn_pkg::*;
#(
    parameter int unsigned N_IN  = 2,
    parameter int unsigned N_OUT = 2,
    parameter int unsigned FRAC  = FRAC_DEF,
    parameter int unsigned ACC_W = 18,
    parameter int unsigned ACT   = 1,
    parameter logic [N_OUT*N_IN*DATA_W-1:0] W_INIT = '0,
    parameter logic [N_OUT*DATA_W-1:0]      B_INIT = '0
) (
    input  logic                clk,
    input  logic                rst,
    nn_dense_layer_if.slave     bus_io
);

    localparam int unsigned AW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned IW = $clog2(N_IN + 1);

    state_e                  state_q, state_d;
    logic [JW-1:0]           j_q, j_d;
    logic [IW-1:0]           i_q, i_d;          // reads issued for this neuron
    logic                    trig_q, trig_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic                    rd_prev_q, rd_prev_d;  // in_data this cycle is a read result
    logic [AW-1:0]           idx_prev_q, idx_prev_d;
    logic                    ack_q, ack_d;
    logic [N_OUT*DATA_W-1:0] out_q, out_d;
    logic [N_OUT*DATA_W-1:0] shadow_q, shadow_d;

    logic                     mac_clr, mac_en;
    logic signed [DATA_W-1:0] w_sel, b_sel, res;

    assign w_sel = W_INIT[w_off(32'(j_q), 32'(idx_prev_q), N_IN) +: DATA_W];
    assign b_sel = B_INIT[32'(j_q) * DATA_W +: DATA_W];

    nn_mac_unit #(
        .FRAC  (FRAC),
        .ACC_W (ACC_W),
        .ACT   (ACT)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (mac_clr),
        .en_i     (mac_en),
        .data_i   (bus_io.in_data),
        .weight_i (w_sel),
        .bias_i   (b_sel),
        .res_o    (res)
    );

    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        i_d        = i_q;
        trig_d     = 1'b0;
        addr_d     = addr_q;
        rd_prev_d  = 1'b0;
        idx_prev_d = idx_prev_q;
        ack_d      = ack_q;
        out_d      = out_q;
        shadow_d   = shadow_q;
        mac_clr    = 1'b0;
        mac_en     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Read index 0 goes out on the entry edge so RUN starts issuing at once.
                if (bus_io.req && !ack_q) begin
                    state_d = RUN;
                    j_d     = '0;
                    mac_clr = 1'b1;
                    trig_d  = 1'b1;
                    addr_d  = '0;
                    i_d     = IW'(1);
                end
            end
            RUN: begin
                if (!bus_io.req) begin
                    state_d = IDLE;
                    mac_clr = 1'b1;
                end else begin
                    if (i_q < IW'(N_IN)) begin
                        trig_d = 1'b1;
                        addr_d = AW'(i_q);
                        i_d    = i_q + IW'(1);
                    end
                    if (trig_q) begin
                        rd_prev_d  = 1'b1;
                        idx_prev_d = addr_q;
                    end
                    if (rd_prev_q) begin
                        mac_en = 1'b1;
                        if (idx_prev_q == AW'(N_IN - 1)) begin
                            state_d = FIN;
                        end
                    end
                end
            end
            FIN: begin
                if (!bus_io.req) begin
                    state_d = IDLE;
                    mac_clr = 1'b1;
                end else begin
                    shadow_d[32'(j_q) * DATA_W +: DATA_W] = res;
                    mac_clr = 1'b1;
                    if (j_q == JW'(N_OUT - 1)) begin
                        state_d = DONE;
                        ack_d   = 1'b1;
                        out_d   = shadow_d;
                    end else begin
                        state_d = RUN;
                        j_d     = j_q + JW'(1);
                        trig_d  = 1'b1;
                        addr_d  = '0;
                        i_d     = IW'(1);
                    end
                end
            end
            DONE: begin
                if (!bus_io.req) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            j_q        <= '0;
            i_q        <= '0;
            trig_q     <= 1'b0;
            addr_q     <= '0;
            rd_prev_q  <= 1'b0;
            idx_prev_q <= '0;
            ack_q      <= 1'b0;
            out_q      <= '0;
            shadow_q   <= '0;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            i_q        <= i_d;
            trig_q     <= trig_d;
            addr_q     <= addr_d;
            rd_prev_q  <= rd_prev_d;
            idx_prev_q <= idx_prev_d;
            ack_q      <= ack_d;
            out_q      <= out_d;
            shadow_q   <= shadow_d;
        end
    end

    assign bus_io.in_rd_trig = trig_q;
    assign bus_io.in_addr    = addr_q;
    assign bus_io.ack_layer  = ack_q;
    assign bus_io.out_vec    = out_q;

endmodule
